// File: rtl/eg4_led_pkg.sv
// Shared constants, mode encoding and PWM compare helper for the eg4 board LED driver.
package eg4_led_pkg;

   localparam int unsigned LED_N    = 3;
   localparam int unsigned CNT_W    = 10;
   localparam int unsigned PWM_W    = 3;
   localparam int unsigned BRIGHT_W = 4;
   localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

   localparam int unsigned CH_R = 0;
   localparam int unsigned CH_G = 1;
   localparam int unsigned CH_B = 2;

   typedef enum logic {
      MODE_UNLOCKED = 1'b0,
      MODE_LOCKED   = 1'b1
   } mode_e;

   // Duty gate: lit while the free-running phase is below the brightness in eighths.
   function automatic logic pwm_gate(input logic [PWM_W-1:0] cnt, input int unsigned bright);
      return 32'(cnt) < bright;
   endfunction

endpackage

// File: rtl/eg4_led_chan.sv
// One LED channel: request-driven pulse stretcher with a combinational active flag.
module eg4_led_chan
   import eg4_led_pkg::*;
#(
   parameter int unsigned STRETCH_MS = 50
)(
   input  logic clk_i,
   input  logic rst_i,
   input  logic ena_ms_i,
   input  logic req_i,
   output logic act_o_c
);

   localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH_MS);

   logic [CNT_W-1:0] stretch_q;
   logic [CNT_W-1:0] stretch_d;

   // A live request reloads and beats a coincident millisecond tick.
   always_comb begin
      stretch_d = stretch_q;
      if (req_i) begin
         stretch_d = STRETCH_LD;
      end else if (ena_ms_i && (stretch_q != '0)) begin
         stretch_d = stretch_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stretch_q <= '0;
      end else begin
         stretch_q <= stretch_d;
      end
   end

   assign act_o_c = req_i | (stretch_q != '0);

endmodule

// File: rtl/eg4_led_drv.sv
// Board LED driver: per-channel stretch, PWM dimming and a PLL-unlocked blink indicator.
module eg4_led_drv
   import eg4_led_pkg::*;
#(
   parameter int unsigned STRETCH_MS = 50,
   parameter int unsigned BRIGHT     = 8,
   parameter int unsigned BLINK_MS   = 250
)(
   input  logic             sys_clk_p,
   input  logic             sys_rst,
   input  logic             ena_ms,
   input  logic             sys_plock,
   input  logic [LED_N-1:0] leds,
   input  logic             tty_stb,
   output logic [LED_N-1:0] led_n
);

   if ((STRETCH_MS < 1) || (STRETCH_MS > CNT_MAX)) begin : g_bad_stretch
      $error("eg4_led_drv: STRETCH_MS out of range");
   end
   if ((BLINK_MS < 1) || (BLINK_MS > CNT_MAX)) begin : g_bad_blink
      $error("eg4_led_drv: BLINK_MS out of range");
   end
   if (BRIGHT > ((1 << BRIGHT_W) - 1)) begin : g_bad_bright
      $error("eg4_led_drv: BRIGHT wider than its field");
   end

   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_MS - 1);

   logic [LED_N-1:0] req_c;
   logic [LED_N-1:0] act_c;
   logic             gate_c;
   logic             plock_fall_c;
   mode_e            mode_c;

   logic [PWM_W-1:0] pwm_q,       pwm_d;
   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_q,     blink_d;
   logic             plock_q,     plock_d;
   logic [LED_N-1:0] led_n_q,     led_n_d;

   // Debug traffic shares the red channel with the core's own request.
   always_comb begin
      req_c       = leds;
      req_c[CH_R] = leds[CH_R] | tty_stb;
   end

   for (genvar gi = 0; gi < LED_N; gi++) begin : g_chan
      eg4_led_chan #(
         .STRETCH_MS (STRETCH_MS)
      ) u_chan (
         .clk_i    (sys_clk_p),
         .rst_i    (sys_rst),
         .ena_ms_i (ena_ms),
         .req_i    (req_c[gi]),
         .act_o_c  (act_c[gi])
      );
   end

   assign gate_c       = pwm_gate(pwm_q, BRIGHT);
   assign plock_fall_c = plock_q & ~sys_plock;
   assign mode_c       = sys_plock ? MODE_LOCKED : MODE_UNLOCKED;

   // Next-state for PWM phase, blink timer and the registered LED drive.
   always_comb begin
      pwm_d       = pwm_q + PWM_W'(1);
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      plock_d     = sys_plock;
      led_n_d     = '1;

      // Restarting on lock loss makes the first lit phase a full half-period away.
      if (plock_fall_c) begin
         blink_cnt_d = '0;
         blink_d     = 1'b0;
      end else if (ena_ms) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
         end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
         end
      end

      // Using blink_d keeps the lock-loss edge from flashing a stale phase.
      case (mode_c)
         MODE_LOCKED:   led_n_d = ~(act_c & {LED_N{gate_c}});
         MODE_UNLOCKED: led_n_d = {LED_N{~blink_d}};
         default:       led_n_d = '1;
      endcase
   end

   always_ff @(posedge sys_clk_p) begin
      if (sys_rst) begin
         pwm_q       <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
         plock_q     <= 1'b0;
         led_n_q     <= '1;
      end else begin
         pwm_q       <= pwm_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
         plock_q     <= plock_d;
         led_n_q     <= led_n_d;
      end
   end

   assign led_n = led_n_q;

endmodule

// File: tb/tb_eg4_led_drv.sv
// Scoreboard bench for eg4_led_drv: three brightness variants driven in lockstep.
module tb_eg4_led_drv;

   localparam int STR = 50;
   localparam int BLK = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b0;
   logic       plock = 1'b1;
   logic [2:0] leds = 3'b000;
   logic       tty = 1'b0;
   logic [2:0] led_a, led_b, led_c;

   int n_chk = 0;
   int n_err = 0;

   // Reference state, kept as elapsed quantities rather than register images.
   int m_rem [3] = '{0, 0, 0};
   int m_cyc = 0;
   int m_ms  = 0;
   bit m_pl  = 1'b0;
   int bright [3] = '{8, 3, 0};

   logic [8:0] exp_q [$];

   always #5 clk = ~clk;

   eg4_led_drv #(.STRETCH_MS(STR), .BRIGHT(8), .BLINK_MS(BLK)) u_dut_a (
      .sys_clk_p(clk), .sys_rst(rst), .ena_ms(ena), .sys_plock(plock),
      .leds(leds), .tty_stb(tty), .led_n(led_a));
   eg4_led_drv #(.STRETCH_MS(STR), .BRIGHT(3), .BLINK_MS(BLK)) u_dut_b (
      .sys_clk_p(clk), .sys_rst(rst), .ena_ms(ena), .sys_plock(plock),
      .leds(leds), .tty_stb(tty), .led_n(led_b));
   eg4_led_drv #(.STRETCH_MS(STR), .BRIGHT(0), .BLINK_MS(BLK)) u_dut_c (
      .sys_clk_p(clk), .sys_rst(rst), .ena_ms(ena), .sys_plock(plock),
      .leds(leds), .tty_stb(tty), .led_n(led_c));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Predict the next edge from current inputs, advance one clock, compare.
   task automatic tick();
      logic [2:0] req;
      logic [2:0] act;
      logic [8:0] e;
      logic [8:0] got;
      bit         fall, gate, blink_n;
      int         ms_n;
      req    = leds;
      req[0] = leds[0] | tty;
      e      = '1;
      if (rst) begin
         for (int i = 0; i < 3; i++) m_rem[i] = 0;
         m_cyc = 0;
         m_ms  = 0;
         m_pl  = 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) act[i] = req[i] || (m_rem[i] > 0);
         fall    = m_pl && !plock;
         ms_n    = fall ? 0 : m_ms + (ena ? 1 : 0);
         blink_n = ((ms_n / BLK) % 2) == 1;
         for (int d = 0; d < 3; d++) begin
            gate = (m_cyc % 8) < bright[d];
            e[3*d +: 3] = plock ? ~(act & {3{gate}}) : {3{~blink_n}};
         end
         for (int i = 0; i < 3; i++) begin
            if (req[i])                    m_rem[i] = STR;
            else if (ena && m_rem[i] > 0)  m_rem[i] = m_rem[i] - 1;
         end
         m_cyc++;
         m_ms = ms_n;
         m_pl = plock;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = {led_c, led_b, led_a};
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check("led_n_a", 32'(got[2:0]), 32'(e[2:0]));
         check("led_n_b", 32'(got[5:3]), 32'(e[5:3]));
         check("led_n_c", 32'(got[8:6]), 32'(e[8:6]));
      end
   endtask

   task automatic ms_step(input int per);
      for (int k = 0; k < per; k++) begin
         ena = (k == per - 1);
         tick();
      end
      ena = 1'b0;
   endtask

   // Count ms strobes until dut_a shows val on the masked bits; bounded.
   task automatic wait_for(input int per, input logic [2:0] mask, input logic [2:0] val,
                           output int n);
      int cyc;
      n   = 0;
      cyc = 0;
      while (((led_a & mask) != val) && (cyc < per * 80)) begin
         ena = ((cyc % per) == per - 1);
         tick();
         if (ena) n++;
         cyc++;
      end
      ena = 1'b0;
   endtask

   initial begin
      int n, lo_a, lo_b, lo_c;

      rst = 1'b1; leds = 3'b111; tty = 1'b1;
      tick();
      tick();
      check("rst_led_a", 32'(led_a), 32'h7);
      rst = 1'b0; leds = 3'b000; tty = 1'b0;

      // Brightness: held blue request, count low cycles across two PWM periods.
      leds = 3'b100;
      lo_a = 0; lo_b = 0; lo_c = 0;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (!led_a[2]) lo_a++;
         if (!led_b[2]) lo_b++;
         if (!led_c[2]) lo_c++;
      end
      check("pwm_lo_b8", 32'(lo_a), 32'd16);
      check("pwm_lo_b3", 32'(lo_b), 32'd6);
      check("pwm_lo_b0", 32'(lo_c), 32'd0);
      leds = 3'b000;
      wait_for(10, 3'b100, 3'b100, n);
      check("blue_stretch_ms", 32'(n), 32'(STR));

      // Single-cycle green pulse, slow ms strobe.
      leds = 3'b010;
      tick();
      check("green_lit_next", 32'(led_a[1]), 32'd0);
      leds = 3'b000;
      wait_for(100, 3'b010, 3'b010, n);
      check("green_stretch_ms", 32'(n), 32'(STR));

      // Debug strobe lights red only.
      tty = 1'b1;
      tick();
      tty = 1'b0;
      check("tty_only_red", 32'(led_a), 32'h6);
      wait_for(10, 3'b001, 3'b001, n);
      check("tty_stretch_ms", 32'(n), 32'(STR));

      // Held red request, released right after a coincident ms strobe.
      leds = 3'b001;
      for (int k = 0; k < 3; k++) ms_step(10);
      leds = 3'b000;
      wait_for(10, 3'b001, 3'b001, n);
      check("hold_drop_ms", 32'(n), 32'(STR));

      // Lock loss: dark for BLK ms, then lit, then dark again; relock next cycle.
      plock = 1'b0;
      tick();
      check("unlock_dark", 32'(led_a), 32'h7);
      wait_for(10, 3'b111, 3'b000, n);
      check("blink_first_lit_ms", 32'(n), 32'(BLK));
      wait_for(10, 3'b111, 3'b111, n);
      check("blink_lit_ms", 32'(n), 32'(BLK));
      for (int k = 0; k < 6; k++) ms_step(10);
      plock = 1'b1;
      tick();
      check("relock_normal", 32'(led_a), 32'h7);
      leds = 3'b010;
      tick();
      check("relock_drive", 32'(led_a), 32'h5);
      leds = 3'b000;

      // Reset part-way through a stretch discards it; inputs ignored in reset.
      for (int k = 0; k < 10; k++) ms_step(10);
      leds = 3'b100;
      tick();
      leds = 3'b000;
      for (int k = 0; k < 10; k++) ms_step(10);
      check("pre_rst_lit", 32'(led_a[2]), 32'd0);
      rst = 1'b1; leds = 3'b111; tty = 1'b1;
      tick();
      check("rst_mid_dark", 32'(led_a), 32'h7);
      tick();
      rst = 1'b0; leds = 3'b000; tty = 1'b0;
      for (int k = 0; k < 3; k++) ms_step(10);
      check("post_rst_dark", 32'(led_a), 32'h7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/eg4_led_drv.md
EG4_LED_DRV -- requirements
Module: eg4_led_drv

Interface
REQ-001 Parameter STRETCH_MS, default 50: minimum lit time in ms after a channel request falls; range 1..1023.
REQ-002 Parameter BRIGHT, default 8: PWM duty in eighths, 4 bits; 0 = always dark, 8 = always lit.
REQ-003 Parameter BLINK_MS, default 250: half-period in ms of the PLL-unlocked blink; range 1..1023.
REQ-004 sys_clk_p  in  1  system clock; all logic on its rising edge.
REQ-005 sys_rst  in  1  reset; synchronous, active-high.
REQ-006 ena_ms  in  1  one-cycle millisecond strobe.
REQ-007 sys_plock  in  1  PLL lock status; asynchronous to nothing, sampled directly.
REQ-008 leds  in  3  per-channel lamp requests from CPU core; active-high level.
REQ-009 tty_stb  in  1  debug-data strobe; one-cycle pulse; activity source for channel 0.
REQ-010 led_n  out  3  board LED drive; active-low; bit 0 = R, 1 = G, 2 = B.

Function
REQ-011 Request per channel: req[i] = leds[i], except req[0] = leds[0] OR tty_stb.
REQ-012 Each channel SHALL keep a 10-bit stretch counter; any cycle with req[i]=1 loads STRETCH_MS.
REQ-013 With req[i]=0 and ena_ms=1, a non-zero stretch counter SHALL decrement by 1; it saturates at 0.
REQ-014 Simultaneous req[i]=1 and ena_ms=1: load wins, no decrement.
REQ-015 Channel active act[i] = req[i] OR (stretch[i] != 0); assertion latency from request 0 cycles combinational into the PWM compare, 1 cycle to led_n.
REQ-016 A free-running 3-bit PWM counter SHALL increment every clock, wrapping 7 -> 0.
REQ-017 PWM gate = (pwm_cnt < BRIGHT); BRIGHT >= 8 makes gate constant 1; BRIGHT = 0 constant 0.
REQ-018 Locked mode (sys_plock=1): led_n[i] registered as NOT(act[i] AND gate).
REQ-019 Unlocked mode (sys_plock=0): stretch counters SHALL keep operating; all three led_n bits show blink phase: led_n = {3{NOT blink}}, PWM gate ignored.
REQ-020 Blink: 10-bit ms counter increments on ena_ms; on reaching BLINK_MS-1 with ena_ms it returns to 0 and blink toggles.
REQ-021 Blink counter and blink phase SHALL reset to 0 on every sys_plock 1 -> 0 transition (detected with one registered copy of sys_plock), so the first lit phase starts BLINK_MS ms after loss of lock.
REQ-022 Mode switch takes effect on led_n one cycle after sys_plock changes; no glitch cycles beyond that.
REQ-023 All led_n updates are registered; no combinational path from inputs to led_n.

Reset
REQ-024 On sys_rst=1 at a clock edge: stretch counters 0, pwm_cnt 0, blink counter 0, blink 0, sys_plock copy 0, led_n = 3'b111 (all dark).
REQ-025 Reset mid-stretch SHALL discard the pending stretch; LED dark the cycle after reset edge unless req[i] asserted after release.
REQ-026 Inputs are ignored while sys_rst=1; first release cycle behaves as a normal cycle.

Structure
REQ-027 Shared package: LED count (3), counter width (10), PWM width (3), channel index constants R/G/B.
REQ-028 One sub-module eg4_led_chan (stretch counter + active output), instantiated 3 times; PWM, blink and mode mux stay in eg4_led_drv.
REQ-029 Block sits between CPU core leds/tty_stb outputs and the eg4_led board pins, replacing the direct inversion.

Verification
REQ-030 Defaults, plock=1, leds[1] pulse 1 cycle, ena_ms every 100 cycles -> led_n[1]=0 from next cycle, returns to 1 after exactly 50 ena_ms strobes.
REQ-031 BRIGHT=3, leds=3'b100 held -> led_n[2] low exactly 3 of every 8 cycles, pwm_cnt 0..2; BRIGHT=0 -> never low.
REQ-032 plock=1 -> 0 with leds=0, BLINK_MS=4 -> led_n=3'b111 for 4 ms, 3'b000 next 4 ms, repeating; plock back to 1 -> normal drive one cycle later.
REQ-033 tty_stb single pulse with leds=0 -> led_n[0] low for STRETCH_MS ms; other channels stay 1.
REQ-034 leds[0] held high while ena_ms toggles, then dropped on an ena_ms cycle -> counter still equals 50 after drop cycle, lit 50 further ms.
REQ-035 sys_rst asserted 10 ms into stretch -> led_n=3'b111 next cycle and stays dark after release with leds=0.
